// File: rtl/axi_bram_responder_if.sv
// AXI4 channel bundle between a master and the block-RAM responder.
// Only the fields the responder acts on are carried; size/lock/cache/prot/qos are not.
interface axi_bram_responder_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_bram_responder.sv
// AXI4 responder backed by block RAM; stands in for the DDR controller.
// One transaction at a time, INCR/FIXED bursts (WRAP handled as INCR).
//
// state     | meaning
// ST_IDLE   | ready for AW or AR; alternates when both are presented
// ST_WDATA  | accepting write beats until the beat count is exhausted
// ST_WRESP  | holding the B response until bready
// ST_RFETCH | RAM read of the current word in flight
// ST_RDATA  | R beat presented, held until rready
module axi_bram_responder #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  nrst,
  axi_bram_responder_if.slave   s_axi
);
  localparam int WA_W  = ADDR_W - 4;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;

  typedef enum logic [2:0] {ST_IDLE, ST_WDATA, ST_WRESP, ST_RFETCH, ST_RDATA} state_t;

  state_t            state_q, state_d;
  logic              last_rd_q;
  logic              en_q;
  logic [ID_W-1:0]   id_q;
  logic [WA_W-1:0]   waddr_q;
  logic [8:0]        beats_q;
  logic              fixed_q;
  logic              err_dec_q;
  logic              err_slv_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              awready, arready, wready, bvalid, rvalid;
  logic              aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic              in_range, last_beat;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_lsb;

  assign in_range  = waddr_q < WA_W'(DEPTH);
  assign last_beat = beats_q == 9'd1;
  assign idx       = waddr_q[IDX_W-1:0];
  assign unused_addr_lsb = ^{s_axi.awaddr[3:0], s_axi.araddr[3:0]};

  assign aw_hs = s_axi.awvalid && awready;
  assign ar_hs = s_axi.arvalid && arready;
  assign w_hs  = s_axi.wvalid && wready;
  assign b_hs  = bvalid && s_axi.bready;
  assign r_hs  = rvalid && s_axi.rready;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; readies held low until the first edge after reset
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        awready = en_q && !(s_axi.arvalid && !last_rd_q);
        arready = en_q && !(s_axi.awvalid && last_rd_q);
        if (s_axi.awvalid && awready)      state_d = ST_WDATA;
        else if (s_axi.arvalid && arready) state_d = ST_RFETCH;
      end
      ST_WDATA: begin
        wready = 1'b1;
        if (s_axi.wvalid && last_beat) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        bvalid = 1'b1;
        if (s_axi.bready) state_d = ST_IDLE;
      end
      ST_RFETCH: state_d = ST_RDATA;
      ST_RDATA: begin
        rvalid = 1'b1;
        if (s_axi.rready) state_d = last_beat ? ST_IDLE : ST_RFETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction context, beat counting, error flags and registered read data
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_q      <= 1'b0;
      last_rd_q <= 1'b1;
      id_q      <= '0;
      waddr_q   <= '0;
      beats_q   <= '0;
      fixed_q   <= 1'b0;
      err_dec_q <= 1'b0;
      err_slv_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      en_q <= 1'b1;
      if (aw_hs) begin
        id_q      <= s_axi.awid;
        waddr_q   <= s_axi.awaddr[ADDR_W-1:4];
        beats_q   <= {1'b0, s_axi.awlen} + 9'd1;
        fixed_q   <= s_axi.awburst == 2'b00;
        err_dec_q <= 1'b0;
        err_slv_q <= 1'b0;
      end else if (ar_hs) begin
        id_q    <= s_axi.arid;
        waddr_q <= s_axi.araddr[ADDR_W-1:4];
        beats_q <= {1'b0, s_axi.arlen} + 9'd1;
        fixed_q <= s_axi.arburst == 2'b00;
      end
      if (w_hs) begin
        if (!in_range) err_dec_q <= 1'b1;
        if (s_axi.wlast != last_beat) err_slv_q <= 1'b1;
        beats_q <= beats_q - 9'd1;
        if (!fixed_q) waddr_q <= waddr_q + 1'b1;
      end
      if (b_hs) last_rd_q <= 1'b0;
      if (state_q == ST_RFETCH) begin
        rdata_q <= in_range ? mem[idx] : '0;
        rresp_q <= in_range ? 2'b00 : 2'b11;
      end
      if (r_hs) begin
        if (last_beat) begin
          last_rd_q <= 1'b1;
        end else begin
          beats_q <= beats_q - 9'd1;
          if (!fixed_q) waddr_q <= waddr_q + 1'b1;
        end
      end
    end
  end

  // Byte-enabled RAM write; out-of-range beats are dropped
  always_ff @(posedge clk) begin
    if (w_hs && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi.wstrb[b]) mem[idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi.awready = awready;
  assign s_axi.arready = arready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bid     = (state_q == ST_WRESP) ? id_q : '0;
  assign s_axi.bresp   = (state_q != ST_WRESP) ? 2'b00 :
                         err_dec_q ? 2'b11 : err_slv_q ? 2'b10 : 2'b00;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rid     = (state_q == ST_RDATA) ? id_q : '0;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = (state_q == ST_RDATA) && last_beat;
endmodule
